countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Kitchen-timer counterpart to the up-counting clock: user sets mm:ss with button pulses, then the block counts down once per second to 00:00 and raises a timed alarm.
- Sits between the button-conditioning block (single-cycle, debounced, active-high pulses) and four SEG7DEC digit decoders.
- Digit outputs use the same BCD split as the clock: 3-bit tens digits, 4-bit ones digits.

Parameters:
- TICK_DIV, 50000000: CLK cycles per one-second tick; the bench uses 4.
- ALARM_SEC, 10: alarm duration in ticks before returning to IDLE automatically.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- start_stop  in  1  one-cycle pulse: start, pause or resume; also acknowledges the alarm.
- clr  in  1  one-cycle pulse: zero the time and go to IDLE.
- minup  in  1  one-cycle pulse: increment minutes while setting.
- secup  in  1  one-cycle pulse: increment seconds while setting.
- min10  out  3  minutes tens digit, 0-5.
- min1  out  4  minutes ones digit, 0-9.
- sec10  out  3  seconds tens digit, 0-5.
- sec1  out  4  seconds ones digit, 0-9.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- blank  out  1  display blanking request for blinking during ALARM.

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE.
  - All digits 0.
  - running = 0, alarm = 0, blank = 0.
  - Tick divider = 0, alarm counter = 0.
- All outputs are registered. A digit change is visible the cycle after the qualifying pulse or tick.
- Tick divider:
  - Counts 0 to TICK_DIV-1 and wraps; tick is asserted when the divider equals TICK_DIV-1.
  - Runs only in RUN and ALARM.
  - Cleared to 0 on every entry to RUN or ALARM, so the first decrement occurs exactly TICK_DIV cycles after the start_stop pulse.
  - A partial second is discarded on pause.
- Priority when pulses coincide: clr > start_stop > minup/secup. A lower-priority pulse in the same cycle is ignored.
- States:
  - IDLE and PAUSE (setting allowed):
    - secup: seconds +1 mod 60 (59 -> 00), no carry into minutes.
    - minup: minutes +1 mod 60.
    - minup and secup together: both apply.
    - start_stop: go to RUN if time != 00:00; ignored if 00:00.
    - clr: digits <= 0, go to IDLE.
  - RUN:
    - On tick, decrement one second:
      - sec1 0 -> 9 with borrow from sec10.
      - sec10:sec1 = 00 -> 59 with borrow from minutes; min1 borrows from min10 the same way.
    - When the decremented value is 00:00, go to ALARM in that same cycle.
    - start_stop: go to PAUSE, digits hold.
    - clr: go to IDLE, digits 0.
    - minup and secup are ignored.
  - ALARM:
    - alarm = 1, digits hold 00:00.
    - blank = 1 while divider >= TICK_DIV/2 (integer division), else 0.
    - Alarm counter increments on each tick. When it reaches ALARM_SEC, go to IDLE and clear the counter.
    - start_stop or clr: go to IDLE immediately.
    - minup and secup are ignored.
- Outputs in non-ALARM states: blank = 0, alarm = 0.
- No underflow below 00:00 in any case.
- Reset asserted mid-RUN or mid-ALARM: immediate return to the reset values above, with no alarm residue.

Test Plan:
- TICK_DIV=4. Reset; secup x3, minup x1 -> 01:03, running=0. start_stop -> running=1; after 4 cycles 01:02; after 12 more cycles 00:59 (minute borrow verified).
- Preset 00:02, start_stop -> 00:01 at cycle 4, 00:00 at cycle 8, alarm=1 the same cycle; blank toggles 0,0,1,1 per tick; alarm=0 and state IDLE after 10 ticks (40 cycles).
- At 00:00 in IDLE, start_stop -> running stays 0; secup x61 -> 00:01 (59 wraps to 00).
- RUN at 00:30, start_stop at divider=2 -> PAUSE at 00:30. secup -> 00:31. start_stop -> first decrement to 00:30 exactly 4 cycles later.
- Same-cycle clr+start_stop in RUN at 05:00 -> 00:00, IDLE, running=0. Same-cycle minup+start_stop in IDLE at 00:10 -> RUN with minutes unchanged.
- Assert RST low mid-ALARM at an asynchronous edge -> all digits, running, alarm and blank are 0 immediately. Release -> IDLE, inputs respond on the next cycle.

Source files
------------

// File: rtl/countdown_timer.sv
// Kitchen countdown timer: mm:ss is set with button pulses, counted down once per
// tick to 00:00, then a blinking alarm runs for ALARM_SEC ticks or until acknowledged.
module countdown_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int ALARM_SEC = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       minup,
    input  logic       secup,
    output logic [2:0] min10,
    output logic [3:0] min1,
    output logic [2:0] sec10,
    output logic [3:0] sec1,
    output logic       running,
    output logic       alarm,
    output logic       blank
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t           state_r, state_nx;
    logic [2:0]       min10_r, min10_nx, sec10_r, sec10_nx;
    logic [3:0]       min1_r, min1_nx, sec1_r, sec1_nx;
    logic [DIV_W-1:0] div_r, div_nx;
    logic [CNT_W-1:0] acnt_r, acnt_nx;
    logic             running_r, alarm_r, blank_r;
    logic             tick_s, time_zero_s, last_sec_s;

    // Increment a BCD 00..59 field, wrapping 59 -> 00 with no carry out.
    function automatic logic [6:0] inc60(input logic [2:0] tens, input logic [3:0] ones);
        logic [6:0] res;
        if (ones != 4'd9) begin
            res = {tens, ones + 4'd1};
        end else if (tens != 3'd5) begin
            res = {tens + 3'd1, 4'd0};
        end else begin
            res = 7'd0;
        end
        return res;
    endfunction

    assign tick_s      = (div_r == DIV_MAX);
    assign time_zero_s = (min10_r == 3'd0) && (min1_r == 4'd0) && (sec10_r == 3'd0) && (sec1_r == 4'd0);
    assign last_sec_s  = (min10_r == 3'd0) && (min1_r == 4'd0) && (sec10_r == 3'd0) && (sec1_r <= 4'd1);

    // Next state, next digits, divider and alarm counter.
    always_comb begin
        state_nx = state_r;
        min10_nx = min10_r;
        min1_nx  = min1_r;
        sec10_nx = sec10_r;
        sec1_nx  = sec1_r;
        div_nx   = {DIV_W{1'b0}};
        acnt_nx  = {CNT_W{1'b0}};
        case (state_r)
            IDLE, PAUSE: begin
                if (clr) begin
                    state_nx = IDLE;
                    min10_nx = 3'd0;
                    min1_nx  = 4'd0;
                    sec10_nx = 3'd0;
                    sec1_nx  = 4'd0;
                end else if (start_stop) begin
                    if (!time_zero_s) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = state_r;
                    end
                end else begin
                    if (minup) begin
                        {min10_nx, min1_nx} = inc60(min10_r, min1_r);
                    end else begin
                        {min10_nx, min1_nx} = {min10_r, min1_r};
                    end
                    if (secup) begin
                        {sec10_nx, sec1_nx} = inc60(sec10_r, sec1_r);
                    end else begin
                        {sec10_nx, sec1_nx} = {sec10_r, sec1_r};
                    end
                end
            end
            RUN: begin
                if (clr) begin
                    state_nx = IDLE;
                    min10_nx = 3'd0;
                    min1_nx  = 4'd0;
                    sec10_nx = 3'd0;
                    sec1_nx  = 4'd0;
                end else if (start_stop) begin
                    state_nx = PAUSE;
                end else if (tick_s) begin
                    // The borrow chain can never pass below 00:00: the last second lands on ALARM.
                    if (last_sec_s) begin
                        state_nx = ALARM;
                        sec1_nx  = 4'd0;
                    end else if (sec1_r != 4'd0) begin
                        sec1_nx = sec1_r - 4'd1;
                    end else begin
                        sec1_nx = 4'd9;
                        if (sec10_r != 3'd0) begin
                            sec10_nx = sec10_r - 3'd1;
                        end else begin
                            sec10_nx = 3'd5;
                            if (min1_r != 4'd0) begin
                                min1_nx = min1_r - 4'd1;
                            end else begin
                                min1_nx  = 4'd9;
                                min10_nx = (min10_r != 3'd0) ? (min10_r - 3'd1) : 3'd0;
                            end
                        end
                    end
                end else begin
                    div_nx = div_r + DIV_W'(1);
                end
            end
            ALARM: begin
                if (clr || start_stop) begin
                    state_nx = IDLE;
                end else if (tick_s) begin
                    if (acnt_r == CNT_LAST) begin
                        state_nx = IDLE;
                    end else begin
                        acnt_nx = acnt_r + CNT_W'(1);
                    end
                end else begin
                    div_nx  = div_r + DIV_W'(1);
                    acnt_nx = acnt_r;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath and registered status outputs, derived from next-cycle values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            min10_r   <= 3'd0;
            min1_r    <= 4'd0;
            sec10_r   <= 3'd0;
            sec1_r    <= 4'd0;
            div_r     <= {DIV_W{1'b0}};
            acnt_r    <= {CNT_W{1'b0}};
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
            blank_r   <= 1'b0;
        end else begin
            min10_r   <= min10_nx;
            min1_r    <= min1_nx;
            sec10_r   <= sec10_nx;
            sec1_r    <= sec1_nx;
            div_r     <= div_nx;
            acnt_r    <= acnt_nx;
            running_r <= (state_nx == RUN);
            alarm_r   <= (state_nx == ALARM);
            blank_r   <= (state_nx == ALARM) && (div_nx >= DIV_HALF);
        end
    end

    assign min10   = min10_r;
    assign min1    = min1_r;
    assign sec10   = sec10_r;
    assign sec1    = sec1_r;
    assign running = running_r;
    assign alarm   = alarm_r;
    assign blank   = blank_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, hand-written corner
// sequences, then random pulses against a seconds-based reference model.
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int AS = 10;
    localparam int MI = 0, MR = 1, MP = 2, MA = 3;

    logic       CLK, RST;
    logic       start_stop, clr, minup, secup;
    logic [2:0] min10, sec10;
    logic [3:0] min1, sec1;
    logic       running, alarm, blank;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: total seconds, mode, cycles into the current second, alarm seconds.
    int m_t, m_mode, m_phase, m_acnt;

    typedef struct {
        bit ss, cl, mu, su;
        int rep;
        int mm, sec;
        bit r;
    } vec_t;
    vec_t tbl[$];

    countdown_timer #(.TICK_DIV(TD), .ALARM_SEC(AS)) dut (
        .CLK(CLK), .RST(RST), .start_stop(start_stop), .clr(clr),
        .minup(minup), .secup(secup), .min10(min10), .min1(min1),
        .sec10(sec10), .sec1(sec1), .running(running), .alarm(alarm), .blank(blank)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [16:0] exp_v(input int mm, input int sec, input bit r, input bit a, input bit b);
        return {3'(mm / 10), 4'(mm % 10), 3'(sec / 10), 4'(sec % 10), r, a, b};
    endfunction

    function automatic string fmt(input logic [16:0] v);
        return $sformatf("%0d%0d:%0d%0d run=%0b alarm=%0b blank=%0b",
                         v[16:14], v[13:10], v[9:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    function automatic vec_t mkv(input bit ss, input bit cl, input bit mu, input bit su,
                                 input int rep, input int mm, input int sec, input bit r);
        vec_t v;
        v.ss = ss; v.cl = cl; v.mu = mu; v.su = su;
        v.rep = rep; v.mm = mm; v.sec = sec; v.r = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = {min10, min1, sec10, sec1, running, alarm, blank};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_mode = MI; m_phase = 0; m_acnt = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit mu, input bit su);
        bit tick;
        int mm, sc;
        tick = (m_mode == MR || m_mode == MA) && (m_phase == TD - 1);
        case (m_mode)
            MI, MP: begin
                if (cl) begin
                    m_t = 0; m_mode = MI;
                end else if (ss) begin
                    if (m_t != 0) begin m_mode = MR; m_phase = 0; end
                end else begin
                    mm = m_t / 60; sc = m_t % 60;
                    if (mu) mm = (mm + 1) % 60;
                    if (su) sc = (sc + 1) % 60;
                    m_t = mm * 60 + sc;
                end
            end
            MR: begin
                if (cl) begin
                    m_t = 0; m_mode = MI; m_phase = 0;
                end else if (ss) begin
                    m_mode = MP; m_phase = 0;
                end else if (tick) begin
                    m_t = m_t - 1; m_phase = 0;
                    if (m_t == 0) begin m_mode = MA; m_acnt = 0; end
                end else begin
                    m_phase++;
                end
            end
            MA: begin
                if (cl || ss) begin
                    m_mode = MI; m_phase = 0; m_acnt = 0;
                end else if (tick) begin
                    m_phase = 0; m_acnt++;
                    if (m_acnt == AS) begin m_mode = MI; m_acnt = 0; end
                end else begin
                    m_phase++;
                end
            end
            default: m_mode = MI;
        endcase
    endtask

    function automatic logic [16:0] model_exp();
        return exp_v(m_t / 60, m_t % 60, m_mode == MR, m_mode == MA,
                     (m_mode == MA) && (m_phase >= TD / 2));
    endfunction

    // One clock cycle with the given pulses; returns #1 after the active edge.
    task automatic pulse(input bit a_ss, input bit a_cl, input bit a_mu, input bit a_su);
        start_stop = a_ss; clr = a_cl; minup = a_mu; secup = a_su;
        @(posedge CLK);
        model_step(a_ss, a_cl, a_mu, a_su);
        #1;
        start_stop = 1'b0; clr = 1'b0; minup = 1'b0; secup = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sec_pulses(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        RST = 1'b0; start_stop = 1'b0; clr = 1'b0; minup = 1'b0; secup = 1'b0;
        model_reset();
        #12;
        check("reset", exp_v(0, 0, 1'b0, 1'b0, 1'b0));
        @(negedge CLK);
        RST = 1'b1;

        //          ss  cl  mu  su  rep mm sec run
        tbl.push_back(mkv(0, 0, 0, 1,  3, 0,  3, 0));
        tbl.push_back(mkv(0, 0, 1, 0,  1, 1,  3, 0));
        tbl.push_back(mkv(1, 0, 0, 0,  1, 1,  3, 1));
        tbl.push_back(mkv(0, 0, 0, 0,  3, 1,  3, 1));
        tbl.push_back(mkv(0, 0, 0, 0,  1, 1,  2, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 12, 0, 59, 1));
        tbl.push_back(mkv(0, 1, 0, 0,  1, 0,  0, 0));
        tbl.push_back(mkv(1, 0, 0, 0,  1, 0,  0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 61, 0,  1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 58, 0, 59, 0));
        tbl.push_back(mkv(0, 0, 0, 1,  1, 0,  0, 0));
        tbl.push_back(mkv(0, 0, 1, 0,  5, 5,  0, 0));
        tbl.push_back(mkv(1, 0, 0, 0,  1, 5,  0, 1));
        tbl.push_back(mkv(0, 0, 0, 0,  1, 5,  0, 1));
        tbl.push_back(mkv(1, 1, 0, 0,  1, 0,  0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 10, 0, 10, 0));
        tbl.push_back(mkv(1, 0, 1, 0,  1, 0, 10, 1));
        tbl.push_back(mkv(0, 0, 0, 1,  1, 0, 10, 1));
        tbl.push_back(mkv(0, 0, 1, 0,  2, 0, 10, 1));
        tbl.push_back(mkv(0, 0, 0, 0,  1, 0,  9, 1));
        tbl.push_back(mkv(0, 1, 0, 0,  1, 0,  0, 0));
        tbl.push_back(mkv(0, 0, 1, 1,  1, 1,  1, 0));
        tbl.push_back(mkv(0, 0, 1, 0, 59, 0,  1, 0));
        tbl.push_back(mkv(0, 1, 0, 0,  1, 0,  0, 0));

        foreach (tbl[i]) begin
            repeat (tbl[i].rep) pulse(tbl[i].ss, tbl[i].cl, tbl[i].mu, tbl[i].su);
            check($sformatf("vec%0d", i), exp_v(tbl[i].mm, tbl[i].sec, tbl[i].r, 1'b0, 1'b0));
        end

        // Countdown into the alarm, blink pattern, and automatic expiry.
        sec_pulses(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3); check("alm_e3", exp_v(0, 2, 1'b1, 1'b0, 1'b0));
        idle(1); check("alm_e4", exp_v(0, 1, 1'b1, 1'b0, 1'b0));
        idle(3); check("alm_e7", exp_v(0, 1, 1'b1, 1'b0, 1'b0));
        idle(1); check("alm_e8", exp_v(0, 0, 1'b0, 1'b1, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            check($sformatf("blink%0d", k), exp_v(0, 0, 1'b0, 1'b1, (k == 2) || (k == 3)));
        end
        idle(35); check("alm_e47", exp_v(0, 0, 1'b0, 1'b1, 1'b1));
        idle(1);  check("alm_e48", exp_v(0, 0, 1'b0, 1'b0, 1'b0));
        sec_pulses(1); check("alm_idle", exp_v(0, 1, 1'b0, 1'b0, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);

        // Pause mid-second, adjust, resume with a fresh full second.
        sec_pulses(30);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0); check("pause", exp_v(0, 30, 1'b0, 1'b0, 1'b0));
        idle(5);                       check("pause_hold", exp_v(0, 30, 1'b0, 1'b0, 1'b0));
        sec_pulses(1);                 check("pause_set", exp_v(0, 31, 1'b0, 1'b0, 1'b0));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);                       check("resume_e3", exp_v(0, 31, 1'b1, 1'b0, 1'b0));
        idle(1);                       check("resume_e4", exp_v(0, 30, 1'b1, 1'b0, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an alarm.
        sec_pulses(1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4); check("rst_alm", exp_v(0, 0, 1'b0, 1'b1, 1'b0));
        idle(2); check("rst_blank", exp_v(0, 0, 1'b0, 1'b1, 1'b1));
        #3;
        RST = 1'b0;
        #1;
        check("rst_async", exp_v(0, 0, 1'b0, 1'b0, 1'b0));
        @(negedge CLK);
        RST = 1'b1;
        sec_pulses(1); check("rst_release", exp_v(0, 1, 1'b0, 1'b0, 1'b0));

        // Random pulses against the reference model.
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int ss_rng;
            bit r_ss, r_cl, r_mu, r_su;
            ss_rng = ((c / 500) % 2 == 0) ? 23 : 199;
            r_ss = ($urandom_range(ss_rng, 0) == 0);
            r_cl = ($urandom_range(127, 0) == 0);
            r_mu = ($urandom_range(39, 0) == 0);
            r_su = ($urandom_range(5, 0) == 0);
            pulse(r_ss, r_cl, r_mu, r_su);
            check($sformatf("rand%0d", c), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
